precision_scalable_accumulator: RTL and testbench
=================================================

Name: precision_scalable_accumulator

Overview:
- Sequential, precision-scalable SIMD accumulator for the PE datapath.
- Replaces the purely combinational per-PE add with a registered accumulator. The accumulator sums a programmable number of partial-product beats in 1, 2 or 4 signed lanes, then presents the result under a valid/ready handshake.
- Adds what the combinational adder lacks: per-lane saturation, sticky overflow flags, a beat counter and output back-pressure.
- Sits between the multiplier array and the output/activation stage.

Parameters:
- ACC_DATA_WIDTH, 32, accumulator and input word width. Must be divisible by 4.
- CNT_WIDTH, 10, width of the beat-count configuration.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_mode  in  3  precision select: 3'b100 = 1 lane of ACC_DATA_WIDTH; 3'b010 = 2 lanes of ACC_DATA_WIDTH/2; 3'b001 = 4 lanes of ACC_DATA_WIDTH/4. Any other code is treated as 3'b100.
- cfg_sat_en  in  1  1 = saturate per lane; 0 = wrap per lane.
- cfg_num_acc  in  CNT_WIDTH  number of beats to accumulate; 0 is treated as 1.
- start  in  1  begin a new accumulation (sampled only in IDLE).
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  ACC_DATA_WIDTH  packed signed lanes; lane k occupies bits [(k+1)*LW-1 : k*LW].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_DATA_WIDTH  packed signed lane results, same layout as in_data.
- out_overflow  out  4  sticky per-lane overflow flags; bit k = lane k; unused lanes read 0.

Behaviour:
- Reset: state = IDLE; accumulator = 0; counter = 0; overflow flags = 0; in_ready = 0; out_valid = 0; out_data = 0; out_overflow = 0.
- Only clock and reset are fixed for this block: one clock, `clk`; reset `reset` is synchronous and active-high.
- Lane width LW = ACC_DATA_WIDTH / number of lanes.
- Lane addition is signed within each lane, with no carry crossing lane boundaries.
- Overflow occurs when both operands have the same sign and the sum has a different sign.
  - On overflow, the lane's sticky flag is set.
  - If cfg_sat_en = 1, the lane is clamped to +2^(LW-1)-1 or -2^(LW-1) according to the operand sign.
  - If cfg_sat_en = 0, the lane wraps.
- State IDLE:
  - in_ready = 0, out_valid = 0.
  - When start = 1: latch cfg_mode, cfg_sat_en and cfg_num_acc (0 becomes 1); clear accumulator, counter and flags; go to ACCUM.
- State ACCUM:
  - in_ready = 1.
  - Each accepted beat updates acc <= lane_add(acc, in_data) and increments the counter.
  - When the accepted beat is number N (the latched count), go to HOLD.
  - Beats with in_valid = 0 are stalls: no change.
- State HOLD:
  - in_ready = 0; out_valid = 1; out_data = acc; out_overflow = flags.
  - out_data and out_overflow are stable while out_valid && !out_ready.
  - On out_ready = 1: go to IDLE; out_valid drops the next cycle; out_data keeps its last value.
- Latency: out_valid rises on the cycle after the clock edge that accepts the Nth beat. Minimum start-to-result time = N+1 cycles with no stalls.
- Mid-operation changes:
  - start and cfg_* changes are ignored outside IDLE.
  - reset has priority over everything and aborts an accumulation in any state; the partial result is discarded.
- Simultaneous start and out_ready in HOLD: only the handshake completes. start is re-sampled in IDLE.

Test Plan:
- Reset mid-ACCUM (after 2 of 5 beats) -> next cycle: IDLE, out_valid = 0, out_data = 0, flags = 0.
- Mode 100, N = 3, beats 0x00000010, 0xFFFFFFF0, 0x00000005 -> out_data = 0x00000005, flags = 0, out_valid 4 cycles after start.
- Mode 010, sat on, N = 2, beats 0x7000_0001 twice -> upper lane = 0x7FFF, lower lane = 0x0002, out_overflow = 4'b0010. Same beats with sat off -> upper lane = 0xE000, same flags.
- Mode 001, N = 1, beat 0x80_7F_01_FF -> out_data = 0x807F01FF, no overflow. Then N = 2 with 0x80808080 twice and sat off -> 0x00000000, flags = 4'b1111.
- Back-pressure: out_ready held 0 for 5 cycles in HOLD -> out_data stable and in_ready = 0 throughout. Beats with in_valid = 0 between accepted beats do not change the result.
- cfg_num_acc = 0 -> behaves as N = 1. start asserted in HOLD together with out_ready -> IDLE next cycle; new run begins only from a later start.

Source files
------------

// File: rtl/precision_scalable_accumulator_if.sv
// Handshake and configuration bundle for the precision-scalable accumulator.
// The master side drives configuration, input beats and out_ready; the slave side is the accumulator.
interface precision_scalable_accumulator_if #(
  parameter int ACC_DATA_WIDTH = 32,
  parameter int CNT_WIDTH      = 10
);
  logic [2:0]                cfg_mode;
  logic                      cfg_sat_en;
  logic [CNT_WIDTH-1:0]      cfg_num_acc;
  logic                      start;
  logic                      in_valid;
  logic                      in_ready;
  logic [ACC_DATA_WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [ACC_DATA_WIDTH-1:0] out_data;
  logic [3:0]                out_overflow;

  modport master (
    output cfg_mode, cfg_sat_en, cfg_num_acc, start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_overflow
  );

  modport slave (
    input  cfg_mode, cfg_sat_en, cfg_num_acc, start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_overflow
  );
endinterface

// File: rtl/precision_scalable_accumulator.sv
// Registered SIMD accumulator: sums N beats in 1, 2 or 4 signed lanes with optional
// per-lane saturation and sticky overflow flags, then holds the result under valid/ready.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for start; configuration is latched on start
//   S_ACCUM | in_ready high, accepting beats until the Nth one lands
//   S_HOLD  | out_valid high, result frozen until out_ready
module precision_scalable_accumulator #(
  parameter int ACC_DATA_WIDTH = 32,
  parameter int CNT_WIDTH      = 10
) (
  input logic clk,
  input logic reset,
  precision_scalable_accumulator_if.slave bus
);
  localparam int W  = ACC_DATA_WIDTH;
  localparam int HW = W / 2;
  localparam int QW = W / 4;

  localparam logic [1:0] M_ONE  = 2'd0;
  localparam logic [1:0] M_TWO  = 2'd1;
  localparam logic [1:0] M_FOUR = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t               state_q;
  logic [1:0]           mode_q;
  logic                 sat_q;
  logic [CNT_WIDTH-1:0] num_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [W-1:0]         acc_q;
  logic [3:0]           flg_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [W-1:0]         out_data_q;
  logic [3:0]           out_ovf_q;

  logic [1:0]           mode_dec;
  logic [CNT_WIDTH-1:0] num_dec;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [W-1:0]         sum1_d, sum2_d, sum4_d, acc_d;
  logic                 ovf1_d;
  logic [1:0]           ovf2_d;
  logic [3:0]           ovf4_d, flg_d;
  logic [HW-1:0]        a2, b2, s2;
  logic [QW-1:0]        a4, b4, s4;

  always_comb begin
    case (bus.cfg_mode)
      3'b010:  mode_dec = M_TWO;
      3'b001:  mode_dec = M_FOUR;
      default: mode_dec = M_ONE;
    endcase
    num_dec = (bus.cfg_num_acc == '0) ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : bus.cfg_num_acc;
    cnt_d   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  // Overflow is same-sign operands producing a sum of the other sign; clamp toward the operand sign.
  always_comb begin
    sum1_d = acc_q + bus.in_data;
    ovf1_d = (acc_q[W-1] == bus.in_data[W-1]) && (sum1_d[W-1] != acc_q[W-1]);
    if (ovf1_d && sat_q)
      sum1_d = acc_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  always_comb begin
    sum2_d = '0;
    ovf2_d = '0;
    a2 = '0;
    b2 = '0;
    s2 = '0;
    for (int k = 0; k < 2; k++) begin
      a2 = acc_q[k*HW +: HW];
      b2 = bus.in_data[k*HW +: HW];
      s2 = a2 + b2;
      ovf2_d[k] = (a2[HW-1] == b2[HW-1]) && (s2[HW-1] != a2[HW-1]);
      if (ovf2_d[k] && sat_q)
        s2 = a2[HW-1] ? {1'b1, {(HW-1){1'b0}}} : {1'b0, {(HW-1){1'b1}}};
      sum2_d[k*HW +: HW] = s2;
    end
  end

  always_comb begin
    sum4_d = '0;
    ovf4_d = '0;
    a4 = '0;
    b4 = '0;
    s4 = '0;
    for (int k = 0; k < 4; k++) begin
      a4 = acc_q[k*QW +: QW];
      b4 = bus.in_data[k*QW +: QW];
      s4 = a4 + b4;
      ovf4_d[k] = (a4[QW-1] == b4[QW-1]) && (s4[QW-1] != a4[QW-1]);
      if (ovf4_d[k] && sat_q)
        s4 = a4[QW-1] ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}};
      sum4_d[k*QW +: QW] = s4;
    end
  end

  always_comb begin
    case (mode_q)
      M_TWO: begin
        acc_d = sum2_d;
        flg_d = flg_q | {2'b00, ovf2_d};
      end
      M_FOUR: begin
        acc_d = sum4_d;
        flg_d = flg_q | ovf4_d;
      end
      default: begin
        acc_d = sum1_d;
        flg_d = flg_q | {3'b000, ovf1_d};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= M_ONE;
      sat_q       <= 1'b0;
      num_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      flg_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            mode_q     <= mode_dec;
            sat_q      <= bus.cfg_sat_en;
            num_q      <= num_dec;
            cnt_q      <= '0;
            acc_q      <= '0;
            flg_q      <= '0;
            in_ready_q <= 1'b1;
            state_q    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (bus.in_valid) begin
            acc_q <= acc_d;
            flg_q <= flg_d;
            cnt_q <= cnt_d;
            if (cnt_d == num_q) begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= acc_d;
              out_ovf_q   <= flg_d;
              state_q     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // start is deliberately ignored here; it is re-sampled once back in IDLE
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_overflow = out_ovf_q;
endmodule

// File: tb/tb_precision_scalable_accumulator.sv
// Directed plus randomized bench for precision_scalable_accumulator; expected results are
// queued as beats are driven and compared when the result is presented.
module tb_precision_scalable_accumulator;
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  f;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_asserts = 0;
  int   n_fails = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  precision_scalable_accumulator_if #(.ACC_DATA_WIDTH(32), .CNT_WIDTH(10)) bus ();

  precision_scalable_accumulator #(.ACC_DATA_WIDTH(32), .CNT_WIDTH(10)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] f);
    exp_t e;
    e.d = d;
    e.f = f;
    sb_q.push_back(e);
  endtask

  task automatic start_run(input logic [2:0] mode, input logic sat, input logic [9:0] n);
    bus.cfg_mode    = mode;
    bus.cfg_sat_en  = sat;
    bus.cfg_num_acc = n;
    bus.start       = 1'b1;
    tick(1);
    bus.start       = 1'b0;
    bus.cfg_mode    = 3'($urandom);
    bus.cfg_sat_en  = 1'($urandom);
    bus.cfg_num_acc = 10'($urandom);
  endtask

  task automatic send_beat(input logic [31:0] d);
    int t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      tick(1);
      t++;
    end
    if (t == 20) chk("in_ready_timeout", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick(1);
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
  endtask

  task automatic stall(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.in_data = $urandom;
      tick(1);
    end
  endtask

  task automatic collect(input string tag);
    int   t = 0;
    exp_t e;
    while (bus.out_valid !== 1'b1 && t < 50) begin
      tick(1);
      t++;
    end
    chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_data"}, bus.out_data, e.d);
    chk({tag, "_ovf"}, {28'b0, bus.out_overflow}, {28'b0, e.f});
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'b0, bus.out_valid}, 32'd0);
    chk({tag, "_data_kept"}, bus.out_data, e.d);
  endtask

  // Reference lane arithmetic on wide signed integers, independent of bit-level overflow tests.
  task automatic model_add(input logic [31:0] a, input logic [31:0] b, input int lanes,
                           input bit sat, output logic [31:0] r, inout logic [3:0] f);
    int     lw;
    longint mask, mx, mn, x, y, s;
    lw   = 32 / lanes;
    mask = (longint'(1) << lw) - 1;
    mx   = (longint'(1) << (lw - 1)) - 1;
    mn   = -mx - 1;
    r    = '0;
    for (int k = 0; k < lanes; k++) begin
      x = longint'(a >> (k * lw)) & mask;
      y = longint'(b >> (k * lw)) & mask;
      if (x > mx) x = x - (mask + 1);
      if (y > mx) y = y - (mask + 1);
      s = x + y;
      if (s > mx || s < mn) begin
        f[k] = 1'b1;
        if (sat) s = (s > mx) ? mx : mn;
      end
      r = r | ((32'(s & mask)) << (k * lw));
    end
  endtask

  task automatic run_model(input logic [2:0] mode, input bit sat, input int n);
    int          lanes;
    int          nn;
    logic [31:0] acc;
    logic [31:0] d;
    logic [3:0]  f;
    lanes = (mode == 3'b010) ? 2 : (mode == 3'b001) ? 4 : 1;
    nn    = (n == 0) ? 1 : n;
    acc   = '0;
    f     = '0;
    start_run(mode, sat, 10'(n));
    for (int i = 0; i < nn; i++) begin
      if ($urandom_range(0, 2) == 0) stall($urandom_range(1, 2));
      d = $urandom;
      send_beat(d);
      model_add(acc, d, lanes, sat, acc, f);
    end
    push_exp(acc, f);
    collect("rnd");
  endtask

  initial begin
    logic [31:0] held;
    int          c0;
    logic [2:0]  modes [5];
    exp_t        e;
    modes[0] = 3'b100;
    modes[1] = 3'b010;
    modes[2] = 3'b001;
    modes[3] = 3'b111;
    modes[4] = 3'b000;

    bus.cfg_mode    = 3'b100;
    bus.cfg_sat_en  = 1'b0;
    bus.cfg_num_acc = 10'd1;
    bus.start       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b0;
    reset           = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_ovf", {28'b0, bus.out_overflow}, 32'd0);

    // single lane, N = 3, latency from start
    c0 = cyc;
    start_run(3'b100, 1'b0, 10'd3);
    chk("m100_in_ready", {31'b0, bus.in_ready}, 32'd1);
    send_beat(32'h0000_0010);
    send_beat(32'hFFFF_FFF0);
    send_beat(32'h0000_0005);
    chk("m100_latency", 32'(cyc - c0), 32'd4);
    push_exp(32'h0000_0005, 4'b0000);
    collect("m100");

    start_run(3'b010, 1'b1, 10'd2);
    send_beat(32'h7000_0001);
    send_beat(32'h7000_0001);
    push_exp(32'h7FFF_0002, 4'b0010);
    collect("m010_sat");

    start_run(3'b010, 1'b0, 10'd2);
    send_beat(32'h7000_0001);
    send_beat(32'h7000_0001);
    push_exp(32'hE000_0002, 4'b0010);
    collect("m010_wrap");

    start_run(3'b001, 1'b0, 10'd1);
    send_beat(32'h807F_01FF);
    push_exp(32'h807F_01FF, 4'b0000);
    collect("m001_n1");

    start_run(3'b001, 1'b0, 10'd2);
    send_beat(32'h8080_8080);
    send_beat(32'h8080_8080);
    push_exp(32'h0000_0000, 4'b1111);
    collect("m001_ovf");

    // stalls between beats, then back-pressure in HOLD
    start_run(3'b100, 1'b0, 10'd2);
    send_beat(32'h1234_5678);
    stall(3);
    send_beat(32'h1111_1111);
    held = bus.out_data;
    chk("bp_first", held, 32'h2345_6789);
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1;
      tick(1);
      chk("bp_data_stable", bus.out_data, 32'h2345_6789);
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.start = 1'b0;
    push_exp(32'h2345_6789, 4'b0000);
    collect("bp");

    // cfg_num_acc = 0 acts as one beat; start with out_ready in HOLD only completes the handshake
    start_run(3'b100, 1'b0, 10'd0);
    send_beat(32'h0000_ABCD);
    chk("n0_valid", {31'b0, bus.out_valid}, 32'd1);
    push_exp(32'h0000_ABCD, 4'b0000);
    e = sb_q.pop_front();
    chk("n0_data", bus.out_data, e.d);
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    tick(1);
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    chk("st_hold_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("st_hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
    tick(2);
    chk("st_hold_no_run", {31'b0, bus.in_ready}, 32'd0);
    start_run(3'b100, 1'b0, 10'd1);
    chk("st_later_run", {31'b0, bus.in_ready}, 32'd1);
    send_beat(32'h0000_0042);
    push_exp(32'h0000_0042, 4'b0000);
    collect("st_later");

    // reset aborts mid-accumulation
    start_run(3'b001, 1'b0, 10'd5);
    send_beat(32'h8080_8080);
    send_beat(32'h8080_8080);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rmid_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rmid_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rmid_data", bus.out_data, 32'd0);
    chk("rmid_ovf", {28'b0, bus.out_overflow}, 32'd0);
    tick(2);
    chk("rmid_idle", {31'b0, bus.in_ready}, 32'd0);

    for (int i = 0; i < 12; i++)
      run_model(modes[$urandom_range(0, 4)], 1'($urandom), $urandom_range(0, 5));

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
